// File: rtl/ram_full_pkg.sv
// Shared types and constants for the two-chip SRAM controller.
// Optional two-cycle strobe is selected with SRAM_WAIT_STATE_EN.
package ram_full_pkg;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 17;
  localparam int RAM_ADDR_W   = 18;
  localparam int CHIP_SEL_BIT = 16;
  localparam int WADDR_W      = ADDR_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    FINISH
  } state_t;

  // Active-low pin strobes plus the data-bus drive enable.
  typedef struct packed {
    logic en_n;
    logic oe_n;
    logic we_n;
    logic drv;
  } strb_t;

  localparam strb_t STRB_OFF = '{
    en_n: 1'b1,
    oe_n: 1'b1,
    we_n: 1'b1,
    drv:  1'b0
  };

  // Pin levels the selected chip should see while in state s.
  function automatic strb_t strobes(
    input state_t s,
    input logic   wr
  );
    strb_t v;
    v = STRB_OFF;
    unique case (s)
      IDLE: ;
      SETUP: begin
        v.en_n = 1'b0;
        v.oe_n = wr;
        v.drv  = wr;
      end
      STROBE: begin
        v.en_n = 1'b0;
        v.oe_n = wr;
        v.we_n = ~wr;
        v.drv  = wr;
      end
      FINISH: begin
        v.en_n = 1'b0;
        v.drv  = wr;
      end
      default: ;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ram_full_ctrl_sram_port.sv
// One SRAM chip's pin registers: strobes, address, write data
// driver and read-data capture. Instantiated once per chip.
module sram_port
  import ram_full_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_sel,
  input  logic                  i_load,
  input  logic [WADDR_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  strb_t                 i_strb,
  input  logic                  i_cap,
  output logic                  o_en_n,
  output logic                  o_oe_n,
  output logic                  o_we_n,
  output logic [RAM_ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0]     o_rd_data,
  inout  wire  [DATA_W-1:0]     io_data
);

  strb_t               r_strb;
  logic [WADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rd;

  // Strobes follow the FSM only for the selected chip.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_strb <= STRB_OFF;
    else      r_strb <= i_sel ? i_strb : STRB_OFF;
  end

  // Address and write data are latched when a request is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_sel && i_load) begin
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end
  end

  // Read data is taken off the pins at the end of the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_rd <= '0;
    else if (i_sel && i_cap) r_rd <= io_data;
  end

  assign io_data   = r_strb.drv ? r_wdata : {DATA_W{1'bz}};
  assign o_en_n    = r_strb.en_n;
  assign o_oe_n    = r_strb.oe_n;
  assign o_we_n    = r_strb.we_n;
  assign o_addr    = {{(RAM_ADDR_W-WADDR_W){1'b0}}, r_addr};
  assign o_rd_data = r_rd;

endmodule

// File: rtl/ram_full_ctrl.sv
// Two-chip async SRAM controller: FSM and chip select.
// Define SRAM_WAIT_STATE_EN for a two-cycle WE/OE strobe.
module ram_full_ctrl
  import ram_full_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  re,
  input  logic                  we,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [ADDR_W-1:0]     addr,
  output logic                  done,
  output logic                  ram1EN,
  output logic                  ram2EN,
  output logic                  ram1OE,
  output logic                  ram2OE,
  output logic                  ram1WE,
  output logic                  ram2WE,
  output logic [RAM_ADDR_W-1:0] ram_addr1,
  output logic [RAM_ADDR_W-1:0] ram_addr2,
  inout  wire  [DATA_W-1:0]     ram_data1,
  inout  wire  [DATA_W-1:0]     ram_data2,
  output logic [DATA_W-1:0]     data_out
);

`ifdef SRAM_WAIT_STATE_EN
  localparam logic [0:0] STRB_LAST = 1'b1;
`else
  localparam logic [0:0] STRB_LAST = 1'b0;
`endif

  state_t              r_state;
  state_t              w_nx_state;
  logic                r_op;
  logic                w_nx_op;
  logic                r_sel;
  logic                w_nx_sel;
  logic [ADDR_W-1:0]   r_addr;
  logic [0:0]          r_strb_cnt;
  logic                r_done;
  logic                w_nx_done;
  logic                r_last_sel;
  logic                w_req;
  logic                w_match;
  logic                w_accept;
  logic                w_strb_end;
  logic                w_cap;
  strb_t               w_strb;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;

  assign w_req      = en & (re | we);
  assign w_match    = w_req & (addr == r_addr) & (we == r_op);
  assign w_strb_end = (r_strb_cnt == STRB_LAST);
  assign w_cap      = (r_state == STROBE) & w_strb_end & ~r_op;

  // Next state; an access in flight always runs to FINISH.
  always_comb begin
    w_nx_state = r_state;
    w_nx_op    = r_op;
    w_nx_sel   = r_sel;
    w_accept   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_nx_state = SETUP;
          w_nx_op    = we;
          w_nx_sel   = addr[CHIP_SEL_BIT];
          w_accept   = 1'b1;
        end
      end
      SETUP:   w_nx_state = STROBE;
      STROBE:  if (w_strb_end) w_nx_state = FINISH;
      FINISH:  if (!w_match) w_nx_state = IDLE;
      default: w_nx_state = IDLE;
    endcase
    w_nx_done = (w_nx_state == FINISH) & w_match;
    w_strb    = strobes(w_nx_state, w_nx_op);
  end

  // FSM state and the latched request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_op    <= 1'b0;
      r_sel   <= 1'b0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_op    <= w_nx_op;
      r_sel   <= w_nx_sel;
      r_done  <= w_nx_done;
      if (w_accept) r_addr <= addr;
    end
  end

  // Strobe length counter for the optional wait state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_strb_cnt <= '0;
    else if (r_state == STROBE && !w_strb_end)
      r_strb_cnt <= r_strb_cnt + 1'b1;
    else
      r_strb_cnt <= '0;
  end

  // Remember which chip produced the most recent read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_last_sel <= 1'b0;
    else if (w_cap) r_last_sel <= r_sel;
  end

  sram_port u_ram1 (
    .clk       (clk),
    .rst       (rst),
    .i_sel     (~w_nx_sel),
    .i_load    (w_accept),
    .i_addr    (addr[WADDR_W-1:0]),
    .i_wdata   (data_in),
    .i_strb    (w_strb),
    .i_cap     (w_cap),
    .o_en_n    (ram1EN),
    .o_oe_n    (ram1OE),
    .o_we_n    (ram1WE),
    .o_addr    (ram_addr1),
    .o_rd_data (w_rd1),
    .io_data   (ram_data1)
  );

  sram_port u_ram2 (
    .clk       (clk),
    .rst       (rst),
    .i_sel     (w_nx_sel),
    .i_load    (w_accept),
    .i_addr    (addr[WADDR_W-1:0]),
    .i_wdata   (data_in),
    .i_strb    (w_strb),
    .i_cap     (w_cap),
    .o_en_n    (ram2EN),
    .o_oe_n    (ram2OE),
    .o_we_n    (ram2WE),
    .o_addr    (ram_addr2),
    .o_rd_data (w_rd2),
    .io_data   (ram_data2)
  );

  assign done     = r_done;
  assign data_out = r_last_sel ? w_rd2 : w_rd1;

endmodule

// File: tb/tb_ram_full_ctrl.sv
// Scoreboard bench for ram_full_ctrl with two behavioural SRAMs
// and a reference memory model.
module tb_ram_full_ctrl;

`ifdef SRAM_WAIT_STATE_EN
  localparam int STRB = 2;
`else
  localparam int STRB = 1;
`endif
  localparam int LAT = STRB + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, re, we;
  logic [15:0] data_in;
  logic [16:0] addr;
  logic        done;
  logic        ram1EN, ram2EN, ram1OE, ram2OE, ram1WE, ram2WE;
  logic [17:0] ram_addr1, ram_addr2;
  wire  [15:0] ram_data1, ram_data2;
  logic [15:0] data_out;

  ram_full_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .re(re), .we(we),
    .data_in(data_in), .addr(addr), .done(done),
    .ram1EN(ram1EN), .ram2EN(ram2EN),
    .ram1OE(ram1OE), .ram2OE(ram2OE),
    .ram1WE(ram1WE), .ram2WE(ram2WE),
    .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
    .ram_data1(ram_data1), .ram_data2(ram_data2),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM chips.
  logic [15:0] m1 [0:65535];
  logic [15:0] m2 [0:65535];
  assign ram_data1 = (!ram1EN && !ram1OE && ram1WE) ?
                     m1[ram_addr1[15:0]] : 16'hzzzz;
  assign ram_data2 = (!ram2EN && !ram2OE && ram2WE) ?
                     m2[ram_addr2[15:0]] : 16'hzzzz;
  always @(posedge ram1WE) if (!ram1EN) m1[ram_addr1[15:0]] = ram_data1;
  always @(posedge ram2WE) if (!ram2EN) m2[ram_addr2[15:0]] = ram_data2;

  // Reference model and scoreboard.
  typedef struct {
    bit          wr;
    logic [16:0] a;
    logic [15:0] d;
    int          lat;
  } exp_t;

  logic [15:0] ref_mem [logic [16:0]];
  logic [16:0] wr_q [$];
  exp_t        sb_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Current access as seen by the pin monitor.
  bit          cur_wr;
  logic [16:0] cur_a;
  logic [15:0] cur_d;
  int          req_id = 0;
  int          seen_id = 0;
  bit          hold_chk = 0;

  int cyc, we_lo, oe_lo, bad_addr, bad_wd, other_act, both_lo;
  bit prev_done = 0;

  always @(posedge clk)
    if (rst && en && (re || we)) cyc++;

  // Monitor: accumulate pin behaviour, compare on each done rise.
  always @(negedge clk) begin
    logic        s_en, s_oe, s_we, o_en, o_oe, o_we;
    logic [17:0] s_addr;
    logic [15:0] s_dat;
    exp_t        e;
    if (req_id != seen_id) begin
      seen_id = req_id;
      cyc = 0; we_lo = 0; oe_lo = 0; bad_addr = 0;
      bad_wd = 0; other_act = 0; both_lo = 0;
    end
    if (rst) begin
      s_en   = cur_a[16] ? ram2EN : ram1EN;
      s_oe   = cur_a[16] ? ram2OE : ram1OE;
      s_we   = cur_a[16] ? ram2WE : ram1WE;
      s_addr = cur_a[16] ? ram_addr2 : ram_addr1;
      s_dat  = cur_a[16] ? ram_data2 : ram_data1;
      o_en   = cur_a[16] ? ram1EN : ram2EN;
      o_oe   = cur_a[16] ? ram1OE : ram2OE;
      o_we   = cur_a[16] ? ram1WE : ram2WE;
      if (!s_we) we_lo++;
      if (!s_oe) oe_lo++;
      if (!s_en && s_addr != {2'b00, cur_a[15:0]}) bad_addr++;
      if (!s_we && s_dat !== cur_d) bad_wd++;
      if (!(o_en && o_oe && o_we)) other_act++;
      if (!s_oe && !s_we) both_lo++;
      if (hold_chk) chk("done_hold", {31'd0, done}, 32'd1);
      if (done && !prev_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("latency", cyc, e.lat);
          chk("we_pulse", we_lo, e.wr ? STRB : 0);
          chk("oe_pulse", oe_lo, e.wr ? 0 : STRB + 1);
          chk("addr_pins", bad_addr, 0);
          chk("wdata_pins", bad_wd, 0);
          chk("other_chip_idle", other_act, 0);
          chk("oe_we_overlap", both_lo, 0);
          if (!e.wr) chk("read_data", {16'd0, data_out}, {16'd0, e.d});
        end
      end
      prev_done = done;
    end else begin
      prev_done = 0;
    end
  end

  task automatic start(input bit wr, input bit both,
                       input logic [16:0] a, input logic [15:0] d,
                       input int lat, input bit push);
    exp_t e;
    @(posedge clk); #2;
    e.wr = wr; e.a = a; e.lat = lat;
    if (wr) begin
      ref_mem[a] = d;
      wr_q.push_back(a);
      e.d = d;
    end else begin
      e.d = ref_mem[a];
    end
    if (push) sb_q.push_back(e);
    cur_wr = wr; cur_a = a; cur_d = wr ? d : 16'hxxxx;
    req_id++;
    en = 1'b1; we = wr; re = ~wr | both;
    data_in = d; addr = a;
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (done && n < 20) begin @(negedge clk); n++; end
    while (!done && n < 20) begin @(negedge clk); n++; end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic hold_drop;
    @(posedge clk); #2 hold_chk = 1;
    @(posedge clk);
    @(posedge clk); #2 hold_chk = 0;
    en = 0; re = 0; we = 0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_strobes",
        {26'd0, ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE},
        32'h3f);
  endtask

  task automatic access(input bit wr, input bit both,
                        input logic [16:0] a, input logic [15:0] d);
    start(wr, both, a, d, LAT, 1);
    wait_done();
    hold_drop();
  endtask

  // Write immediately followed by a read of the same word.
  task automatic chained(input logic [16:0] a, input logic [15:0] d);
    start(1, 0, a, d, LAT, 1);
    wait_done();
    start(0, 0, a, 16'h0, LAT + 1, 1);
    wait_done();
    hold_drop();
  endtask

  task automatic wait_we_low(input bit chip2);
    int n;
    n = 0;
    while ((chip2 ? ram2WE : ram1WE) && n < 20) begin
      @(negedge clk); n++;
    end
    if (chip2 ? ram2WE : ram1WE) chk("we_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    logic [16:0] a;
    logic [15:0] d;
    rst = 0; en = 0; re = 0; we = 0; data_in = 0; addr = 0;
    cur_wr = 0; cur_a = 0; cur_d = 0;
    #12;
    chk("rst_strobes",
        {26'd0, ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE}, 32'h3f);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data_out", {16'd0, data_out}, 32'd0);
    chk("rst_addr1", {14'd0, ram_addr1}, 32'd0);
    chk("rst_addr2", {14'd0, ram_addr2}, 32'd0);
    @(negedge clk) rst = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_strobes",
        {26'd0, ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE}, 32'h3f);
    chk("post_rst_done", {31'd0, done}, 32'd0);

    chained(17'h00005, 16'h000E);
    access(1, 0, 17'h10005, 16'h000E);
    access(0, 0, 17'h10005, 16'h0);
    access(1, 0, 17'h10005, 16'hBEEF);
    access(0, 0, 17'h00005, 16'h0);
    access(0, 0, 17'h10005, 16'h0);
    access(1, 1, 17'h0000A, 16'h1234);
    access(0, 0, 17'h0000A, 16'h0);
    access(1, 0, 17'h1FFFF, 16'hFFFF);
    access(0, 0, 17'h1FFFF, 16'h0);

    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 5);
      a = 17'($urandom_range(0, 17'h1FFFF));
      d = 16'($urandom);
      if (r == 0)
        chained(a, d);
      else if (r <= 2 || wr_q.size() == 0)
        access(1, r == 2, a, d);
      else
        access(0, 0, wr_q[$urandom_range(0, wr_q.size() - 1)], 16'h0);
    end

    // Enable dropped during the strobe: write lands, no done.
    start(1, 0, 17'h00077, 16'hA5A5, LAT, 0);
    wait_we_low(0);
    #1 en = 0; re = 0; we = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    chk("abort_we_pulse", we_lo, STRB);
    chk("abort_idle_strobes",
        {26'd0, ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE}, 32'h3f);
    access(0, 0, 17'h00077, 16'h0);

    // Reset during a strobe releases the pins at once.
    start(1, 0, 17'h1ABCD, 16'h5555, LAT, 0);
    wait_we_low(1);
    #1 rst = 0;
    #1;
    chk("async_rst_strobes",
        {26'd0, ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE}, 32'h3f);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_data_out", {16'd0, data_out}, 32'd0);
    chk("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
